// File: rtl/cpu_defs.sv
// Shared encodings for the multi-cycle MIPS-subset controller: opcodes, funct
// codes, ALU/PC select codes, FSM states and decoded instruction classes.
package cpu_defs;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;

  localparam logic [1:0] ALUC_ADD = 2'b00;
  localparam logic [1:0] ALUC_SUB = 2'b01;
  localparam logic [1:0] ALUC_AND = 2'b10;
  localparam logic [1:0] ALUC_OR  = 2'b11;

  localparam logic [1:0] PCSRC_PC4 = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b10;
  localparam logic [1:0] PCSRC_JMP = 2'b11;

  localparam int unsigned WAIT_W = 8;

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EX   = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b101
  } state_e;

  typedef enum logic [2:0] {
    IC_ALU_R,
    IC_ALU_I,
    IC_LOAD,
    IC_STORE,
    IC_BEQ,
    IC_BNE,
    IC_JUMP,
    IC_ILLEGAL
  } iclass_e;

endpackage

// File: rtl/inst_decode.sv
// Combinational opcode/funct decoder: instruction class plus the ALU and
// extender selects that stay constant for the life of the instruction.
module inst_decode
  import cpu_defs::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] func_i,
  output iclass_e    cls_o,
  output logic [1:0] aluc_o,
  output logic       se_o,
  output logic       regrt_o,
  output logic       aluqb_o
);

  always_comb begin
    cls_o   = IC_ILLEGAL;
    aluc_o  = ALUC_ADD;
    se_o    = 1'b0;
    regrt_o = 1'b0;
    aluqb_o = 1'b0;
    case (op_i)
      OP_RTYPE: begin
        case (func_i)
          FN_ADD: begin cls_o = IC_ALU_R; aluc_o = ALUC_ADD; se_o = 1'b1; end
          FN_SUB: begin cls_o = IC_ALU_R; aluc_o = ALUC_SUB; se_o = 1'b1; end
          FN_AND: begin cls_o = IC_ALU_R; aluc_o = ALUC_AND; se_o = 1'b1; end
          FN_OR:  begin cls_o = IC_ALU_R; aluc_o = ALUC_OR;  se_o = 1'b1; end
          default: cls_o = IC_ILLEGAL;
        endcase
      end
      OP_ADDI: begin
        cls_o = IC_ALU_I; aluc_o = ALUC_ADD; se_o = 1'b1; regrt_o = 1'b1; aluqb_o = 1'b1;
      end
      OP_ANDI: begin
        cls_o = IC_ALU_I; aluc_o = ALUC_AND; regrt_o = 1'b1; aluqb_o = 1'b1;
      end
      OP_ORI: begin
        cls_o = IC_ALU_I; aluc_o = ALUC_OR; regrt_o = 1'b1; aluqb_o = 1'b1;
      end
      OP_LW: begin
        cls_o = IC_LOAD; se_o = 1'b1; regrt_o = 1'b1; aluqb_o = 1'b1;
      end
      OP_SW: begin
        cls_o = IC_STORE; se_o = 1'b1; regrt_o = 1'b1; aluqb_o = 1'b1;
      end
      OP_BEQ: begin
        cls_o = IC_BEQ; aluc_o = ALUC_SUB; se_o = 1'b1; regrt_o = 1'b1;
      end
      OP_BNE: begin
        cls_o = IC_BNE; aluc_o = ALUC_SUB; se_o = 1'b1; regrt_o = 1'b1;
      end
      OP_J:    cls_o = IC_JUMP;
      default: cls_o = IC_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the MIPS-subset datapath: IF/ID/EX/MEM/WB steps,
// variable-latency memory handshake, sticky halt on illegal opcode or timeout.
module multicycle_ctrl
  import cpu_defs::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic       Clk,
  input  logic       Clrn,
  input  logic [5:0] Op,
  input  logic [5:0] Func,
  input  logic       Z,
  input  logic       Mrdy,
  output logic       Mreq,
  output logic       Iord,
  output logic       Wir,
  output logic       Wpc,
  output logic [1:0] Pcsrc,
  output logic       Wreg,
  output logic       Wmem,
  output logic       Regrt,
  output logic       Se,
  output logic       Aluqb,
  output logic [1:0] Aluc,
  output logic       Reg2reg,
  output logic       Retire,
  output logic       Halt,
  output logic       Err,
  output logic [2:0] State
);

  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_MAX);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              err_q, err_d;

  iclass_e    cls;
  logic [1:0] dec_aluc;
  logic       dec_se;
  logic       dec_regrt;
  logic       dec_aluqb;

  inst_decode u_dec (
    .op_i    (Op),
    .func_i  (Func),
    .cls_o   (cls),
    .aluc_o  (dec_aluc),
    .se_o    (dec_se),
    .regrt_o (dec_regrt),
    .aluqb_o (dec_aluqb)
  );

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state_q <= S_IF;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // cnt_d defaults to zero, so any state change clears the wait counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    err_d   = err_q;
    Mreq    = 1'b0;
    Iord    = 1'b0;
    Wir     = 1'b0;
    Wpc     = 1'b0;
    Pcsrc   = PCSRC_PC4;
    Wreg    = 1'b0;
    Wmem    = 1'b0;
    Regrt   = 1'b0;
    Se      = 1'b0;
    Aluqb   = 1'b0;
    Aluc    = ALUC_ADD;
    Reg2reg = 1'b0;
    Retire  = 1'b0;
    case (state_q)
      S_IF: begin
        Mreq = 1'b1;
        if (Mrdy) begin
          Wir     = 1'b1;
          Wpc     = 1'b1;
          Pcsrc   = PCSRC_PC4;
          state_d = S_ID;
        end else if (cnt_q == WAIT_LIM) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ID: begin
        if (cls == IC_ILLEGAL) begin
          state_d = S_HALT;
        end else if (cls == IC_JUMP) begin
          Wpc     = 1'b1;
          Pcsrc   = PCSRC_JMP;
          Retire  = 1'b1;
          state_d = S_IF;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        Aluc  = dec_aluc;
        Aluqb = dec_aluqb;
        Se    = dec_se;
        Regrt = dec_regrt;
        case (cls)
          IC_BEQ, IC_BNE: begin
            Retire  = 1'b1;
            state_d = S_IF;
            if ((cls == IC_BEQ && Z) || (cls == IC_BNE && !Z)) begin
              Wpc   = 1'b1;
              Pcsrc = PCSRC_BR;
            end
          end
          IC_LOAD, IC_STORE: state_d = S_MEM;
          default:           state_d = S_WB;
        endcase
      end
      S_MEM: begin
        // ALU selects held so the address in R stays stable for the access.
        Aluc  = dec_aluc;
        Aluqb = dec_aluqb;
        Se    = dec_se;
        Regrt = dec_regrt;
        Mreq  = 1'b1;
        Iord  = 1'b1;
        Wmem  = (cls == IC_STORE);
        if (Mrdy) begin
          if (cls == IC_STORE) begin
            Retire  = 1'b1;
            state_d = S_IF;
          end else begin
            state_d = S_WB;
          end
        end else if (cnt_q == WAIT_LIM) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WB: begin
        Aluc    = dec_aluc;
        Aluqb   = dec_aluqb;
        Se      = dec_se;
        Regrt   = dec_regrt;
        Wreg    = 1'b1;
        Reg2reg = (cls != IC_LOAD);
        Retire  = 1'b1;
        state_d = S_IF;
      end
      S_HALT: state_d = S_HALT;
      default: begin
        state_d = S_HALT;
        err_d   = 1'b1;
      end
    endcase
  end

  assign Halt  = (state_q == S_HALT);
  assign Err   = err_q;
  assign State = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle stimulus and expected
// control vectors are queued, then replayed and compared at the falling edge.
module tb_multicycle_ctrl;

  localparam logic [2:0] S_IF   = 3'b000;
  localparam logic [2:0] S_ID   = 3'b001;
  localparam logic [2:0] S_EX   = 3'b010;
  localparam logic [2:0] S_MEM  = 3'b011;
  localparam logic [2:0] S_WB   = 3'b100;
  localparam logic [2:0] S_HALT = 3'b101;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;

  logic       Clk = 1'b0;
  logic       Clrn = 1'b0;
  logic [5:0] Op = '0;
  logic [5:0] Func = '0;
  logic       Z = 1'b0;
  logic       Mrdy = 1'b0;
  logic       Mreq, Iord, Wir, Wpc, Wreg, Wmem, Regrt, Se, Aluqb, Reg2reg;
  logic       Retire, Halt, Err;
  logic [1:0] Pcsrc, Aluc;
  logic [2:0] State;

  multicycle_ctrl #(.WAIT_MAX(15)) dut (
    .Clk(Clk), .Clrn(Clrn), .Op(Op), .Func(Func), .Z(Z), .Mrdy(Mrdy),
    .Mreq(Mreq), .Iord(Iord), .Wir(Wir), .Wpc(Wpc), .Pcsrc(Pcsrc),
    .Wreg(Wreg), .Wmem(Wmem), .Regrt(Regrt), .Se(Se), .Aluqb(Aluqb),
    .Aluc(Aluc), .Reg2reg(Reg2reg), .Retire(Retire), .Halt(Halt),
    .Err(Err), .State(State)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [2:0] st;
    logic       mreq, iord, wir, wpc;
    logic [1:0] pcsrc;
    logic       wreg, wmem, regrt, aluqb;
    logic [1:0] aluc;
    logic       se, reg2reg, retire, halt, err;
  } vec_t;

  typedef struct {
    string      name;
    logic       rstn;
    logic [5:0] op;
    logic [5:0] func;
    logic       mrdy;
    logic       z;
    vec_t       v;
    vec_t       m;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  vec_t obs;
  vec_t MD, MR, MS, MA, MNP;

  assign obs = {State, Mreq, Iord, Wir, Wpc, Pcsrc, Wreg, Wmem, Regrt, Aluqb,
                Aluc, Se, Reg2reg, Retire, Halt, Err};

  task automatic push(input string n, input logic rstn, input logic [5:0] op,
                      input logic [5:0] func, input logic mrdy, input logic z,
                      input vec_t v, input vec_t m);
    exp_t e;
    e.name = n; e.rstn = rstn; e.op = op; e.func = func;
    e.mrdy = mrdy; e.z = z; e.v = v; e.m = m;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 2; i++)
      push("reset", 1'b0, OP_R, F_ADD, 1'b0, 1'b0,
           vec_t'{st:S_IF, mreq:1'b1, default:'0}, MA);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      Clrn = e.rstn; Op = e.op; Func = e.func; Mrdy = e.mrdy; Z = e.z;
      @(negedge Clk);
      checks++;
      if ((obs & e.m) !== (e.v & e.m)) begin
        errors++;
        $display("FAIL %s t=%0t got %h want %h mask %h", e.name, $time, obs, e.v, e.m);
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_rtype();
    exp_t       e;
    logic [5:0] fn[4];
    logic [1:0] ac[4];
    fn = '{F_ADD, F_SUB, F_AND, F_OR};
    ac = '{2'b00, 2'b01, 2'b10, 2'b11};
    for (int i = 0; i < 4; i++) begin
      push("rtype_if", 1'b1, OP_R, fn[i], 1'b1, 1'b0,
           vec_t'{st:S_IF, mreq:1'b1, wir:1'b1, wpc:1'b1, default:'0}, MD);
      push("rtype_id", 1'b1, OP_R, fn[i], 1'b1, 1'b0, vec_t'{st:S_ID, default:'0}, MD);
      push("rtype_ex", 1'b1, OP_R, fn[i], 1'b1, 1'b0,
           vec_t'{st:S_EX, aluc:ac[i], default:'0}, MD);
      push("rtype_wb", 1'b1, OP_R, fn[i], 1'b1, 1'b0,
           vec_t'{st:S_WB, wreg:1'b1, reg2reg:1'b1, aluc:ac[i], retire:1'b1, default:'0}, MR);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      Clrn = e.rstn; Op = e.op; Func = e.func; Mrdy = e.mrdy; Z = e.z;
      @(negedge Clk);
      checks++;
      if ((obs & e.m) !== (e.v & e.m)) begin
        errors++;
        $display("FAIL %s t=%0t got %h want %h mask %h", e.name, $time, obs, e.v, e.m);
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_itype();
    exp_t       e;
    logic [5:0] op[3];
    logic [1:0] ac[3];
    logic       se[3];
    op = '{OP_ADDI, OP_ANDI, OP_ORI};
    ac = '{2'b00, 2'b10, 2'b11};
    se = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      push("itype_if", 1'b1, op[i], 6'b000111, 1'b1, 1'b0,
           vec_t'{st:S_IF, mreq:1'b1, wir:1'b1, wpc:1'b1, default:'0}, MD);
      push("itype_id", 1'b1, op[i], 6'b000111, 1'b1, 1'b0, vec_t'{st:S_ID, default:'0}, MD);
      push("itype_ex", 1'b1, op[i], 6'b000111, 1'b1, 1'b0,
           vec_t'{st:S_EX, aluqb:1'b1, aluc:ac[i], se:se[i], default:'0}, MS);
      push("itype_wb", 1'b1, op[i], 6'b000111, 1'b1, 1'b0,
           vec_t'{st:S_WB, wreg:1'b1, regrt:1'b1, aluqb:1'b1, aluc:ac[i], se:se[i],
                  reg2reg:1'b1, retire:1'b1, default:'0}, MA);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      Clrn = e.rstn; Op = e.op; Func = e.func; Mrdy = e.mrdy; Z = e.z;
      @(negedge Clk);
      checks++;
      if ((obs & e.m) !== (e.v & e.m)) begin
        errors++;
        $display("FAIL %s t=%0t got %h want %h mask %h", e.name, $time, obs, e.v, e.m);
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_load_wait();
    exp_t e;
    push("lw_if", 1'b1, OP_LW, 6'b000100, 1'b1, 1'b0,
         vec_t'{st:S_IF, mreq:1'b1, wir:1'b1, wpc:1'b1, default:'0}, MD);
    push("lw_id", 1'b1, OP_LW, 6'b000100, 1'b1, 1'b0, vec_t'{st:S_ID, default:'0}, MD);
    push("lw_ex", 1'b1, OP_LW, 6'b000100, 1'b1, 1'b0,
         vec_t'{st:S_EX, aluqb:1'b1, se:1'b1, default:'0}, MS);
    for (int i = 0; i < 3; i++)
      push("lw_mem_wait", 1'b1, OP_LW, 6'b000100, 1'b0, 1'b0,
           vec_t'{st:S_MEM, mreq:1'b1, iord:1'b1, aluqb:1'b1, se:1'b1, default:'0}, MS);
    push("lw_mem_rdy", 1'b1, OP_LW, 6'b000100, 1'b1, 1'b0,
         vec_t'{st:S_MEM, mreq:1'b1, iord:1'b1, aluqb:1'b1, se:1'b1, default:'0}, MS);
    push("lw_wb", 1'b1, OP_LW, 6'b000100, 1'b1, 1'b0,
         vec_t'{st:S_WB, wreg:1'b1, regrt:1'b1, aluqb:1'b1, se:1'b1, retire:1'b1, default:'0}, MA);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      Clrn = e.rstn; Op = e.op; Func = e.func; Mrdy = e.mrdy; Z = e.z;
      @(negedge Clk);
      checks++;
      if ((obs & e.m) !== (e.v & e.m)) begin
        errors++;
        $display("FAIL %s t=%0t got %h want %h mask %h", e.name, $time, obs, e.v, e.m);
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_store();
    exp_t e;
    push("sw_if", 1'b1, OP_SW, 6'b001000, 1'b1, 1'b0,
         vec_t'{st:S_IF, mreq:1'b1, wir:1'b1, wpc:1'b1, default:'0}, MD);
    push("sw_id", 1'b1, OP_SW, 6'b001000, 1'b1, 1'b0, vec_t'{st:S_ID, default:'0}, MD);
    push("sw_ex", 1'b1, OP_SW, 6'b001000, 1'b1, 1'b0,
         vec_t'{st:S_EX, aluqb:1'b1, se:1'b1, default:'0}, MS);
    push("sw_mem_wait", 1'b1, OP_SW, 6'b001000, 1'b0, 1'b0,
         vec_t'{st:S_MEM, mreq:1'b1, iord:1'b1, wmem:1'b1, aluqb:1'b1, se:1'b1, default:'0}, MS);
    push("sw_mem_rdy", 1'b1, OP_SW, 6'b001000, 1'b1, 1'b0,
         vec_t'{st:S_MEM, mreq:1'b1, iord:1'b1, wmem:1'b1, aluqb:1'b1, se:1'b1,
                retire:1'b1, default:'0}, MS);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      Clrn = e.rstn; Op = e.op; Func = e.func; Mrdy = e.mrdy; Z = e.z;
      @(negedge Clk);
      checks++;
      if ((obs & e.m) !== (e.v & e.m)) begin
        errors++;
        $display("FAIL %s t=%0t got %h want %h mask %h", e.name, $time, obs, e.v, e.m);
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_branch();
    exp_t       e;
    logic [5:0] op[4];
    logic       zf[4];
    logic       tk[4];
    op = '{OP_BEQ, OP_BEQ, OP_BNE, OP_BNE};
    zf = '{1'b1, 1'b0, 1'b0, 1'b1};
    tk = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      push("br_if", 1'b1, op[i], 6'b000011, 1'b1, zf[i],
           vec_t'{st:S_IF, mreq:1'b1, wir:1'b1, wpc:1'b1, default:'0}, MD);
      push("br_id", 1'b1, op[i], 6'b000011, 1'b1, zf[i], vec_t'{st:S_ID, default:'0}, MD);
      push("br_ex", 1'b1, op[i], 6'b000011, 1'b1, zf[i],
           vec_t'{st:S_EX, wpc:tk[i], pcsrc:(tk[i] ? 2'b10 : 2'b00), aluc:2'b01,
                  retire:1'b1, default:'0}, (tk[i] ? MD : MNP));
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      Clrn = e.rstn; Op = e.op; Func = e.func; Mrdy = e.mrdy; Z = e.z;
      @(negedge Clk);
      checks++;
      if ((obs & e.m) !== (e.v & e.m)) begin
        errors++;
        $display("FAIL %s t=%0t got %h want %h mask %h", e.name, $time, obs, e.v, e.m);
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_back_to_back_jump();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      push("j_if", 1'b1, OP_J, 6'b010000, 1'b1, 1'b0,
           vec_t'{st:S_IF, mreq:1'b1, wir:1'b1, wpc:1'b1, default:'0}, MD);
      push("j_id", 1'b1, OP_J, 6'b010000, 1'b1, 1'b0,
           vec_t'{st:S_ID, wpc:1'b1, pcsrc:2'b11, retire:1'b1, default:'0}, MD);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      Clrn = e.rstn; Op = e.op; Func = e.func; Mrdy = e.mrdy; Z = e.z;
      @(negedge Clk);
      checks++;
      if ((obs & e.m) !== (e.v & e.m)) begin
        errors++;
        $display("FAIL %s t=%0t got %h want %h mask %h", e.name, $time, obs, e.v, e.m);
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_illegal();
    exp_t e;
    push("ill_if", 1'b1, 6'b111111, 6'b000000, 1'b1, 1'b0,
         vec_t'{st:S_IF, mreq:1'b1, wir:1'b1, wpc:1'b1, default:'0}, MD);
    push("ill_id", 1'b1, 6'b111111, 6'b000000, 1'b1, 1'b0, vec_t'{st:S_ID, default:'0}, MD);
    for (int i = 0; i < 20; i++)
      push("ill_halt", 1'b1, 6'b111111, 6'b000000, 1'b1, 1'b1,
           vec_t'{st:S_HALT, halt:1'b1, default:'0}, MA);
    push("ill_reset", 1'b0, 6'b111111, 6'b000000, 1'b0, 1'b0,
         vec_t'{st:S_IF, mreq:1'b1, default:'0}, MA);
    push("badfn_if", 1'b1, OP_R, 6'b000001, 1'b1, 1'b0,
         vec_t'{st:S_IF, mreq:1'b1, wir:1'b1, wpc:1'b1, default:'0}, MD);
    push("badfn_id", 1'b1, OP_R, 6'b000001, 1'b1, 1'b0, vec_t'{st:S_ID, default:'0}, MD);
    push("badfn_halt", 1'b1, OP_R, 6'b000001, 1'b1, 1'b0,
         vec_t'{st:S_HALT, halt:1'b1, default:'0}, MA);
    push("badfn_reset", 1'b0, OP_R, 6'b000001, 1'b0, 1'b0,
         vec_t'{st:S_IF, mreq:1'b1, default:'0}, MA);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      Clrn = e.rstn; Op = e.op; Func = e.func; Mrdy = e.mrdy; Z = e.z;
      @(negedge Clk);
      checks++;
      if ((obs & e.m) !== (e.v & e.m)) begin
        errors++;
        $display("FAIL %s t=%0t got %h want %h mask %h", e.name, $time, obs, e.v, e.m);
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    for (int i = 0; i < 16; i++)
      push("to_if_wait", 1'b1, OP_R, F_ADD, 1'b0, 1'b0,
           vec_t'{st:S_IF, mreq:1'b1, default:'0}, MA);
    for (int i = 0; i < 2; i++)
      push("to_halt", 1'b1, OP_R, F_ADD, 1'b1, 1'b0,
           vec_t'{st:S_HALT, halt:1'b1, err:1'b1, default:'0}, MA);
    push("to_reset", 1'b0, OP_R, F_ADD, 1'b0, 1'b0,
         vec_t'{st:S_IF, mreq:1'b1, default:'0}, MA);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      Clrn = e.rstn; Op = e.op; Func = e.func; Mrdy = e.mrdy; Z = e.z;
      @(negedge Clk);
      checks++;
      if ((obs & e.m) !== (e.v & e.m)) begin
        errors++;
        $display("FAIL %s t=%0t got %h want %h mask %h", e.name, $time, obs, e.v, e.m);
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_mrdy_at_limit();
    exp_t e;
    for (int i = 0; i < 15; i++)
      push("lim_if_wait", 1'b1, OP_R, F_ADD, 1'b0, 1'b0,
           vec_t'{st:S_IF, mreq:1'b1, default:'0}, MA);
    push("lim_if_rdy", 1'b1, OP_R, F_ADD, 1'b1, 1'b0,
         vec_t'{st:S_IF, mreq:1'b1, wir:1'b1, wpc:1'b1, default:'0}, MD);
    push("lim_id", 1'b1, OP_R, F_ADD, 1'b1, 1'b0, vec_t'{st:S_ID, default:'0}, MD);
    push("lim_ex", 1'b1, OP_R, F_ADD, 1'b1, 1'b0, vec_t'{st:S_EX, default:'0}, MD);
    push("lim_wb", 1'b1, OP_R, F_ADD, 1'b1, 1'b0,
         vec_t'{st:S_WB, wreg:1'b1, reg2reg:1'b1, retire:1'b1, default:'0}, MR);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      Clrn = e.rstn; Op = e.op; Func = e.func; Mrdy = e.mrdy; Z = e.z;
      @(negedge Clk);
      checks++;
      if ((obs & e.m) !== (e.v & e.m)) begin
        errors++;
        $display("FAIL %s t=%0t got %h want %h mask %h", e.name, $time, obs, e.v, e.m);
      end
      @(posedge Clk); #1;
    end
  endtask

  initial begin
    MA = '1;
    MD = '1;
    MD.se = 1'b0;
    MD.regrt = 1'b0;
    MR = MD;
    MR.regrt = 1'b1;
    MS = MD;
    MS.se = 1'b1;
    MNP = MD;
    MNP.pcsrc = '0;

    test_reset();
    test_rtype();
    test_itype();
    test_load_wait();
    test_store();
    test_branch();
    test_back_to_back_jump();
    test_illegal();
    test_timeout();
    test_mrdy_at_limit();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
